// File: rtl/dram_cycle_sched_pkg.sv
// Shared types and constants for the DRAM cycle scheduler: state encoding,
// default strobe timing and the registered pin bundle decoded per state.
package dram_cycle_sched_pkg;

  localparam int unsigned CNT_W        = 3;
  localparam int unsigned TRCD_DEF     = 2;
  localparam int unsigned TRAS_REF_DEF = 3;
  localparam int unsigned TRP_DEF      = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACC_RAS  = 3'd1,
    ST_ACC_CAS  = 3'd2,
    ST_ACC_HOLD = 3'd3,
    ST_REF_CAS  = 3'd4,
    ST_REF_RAS  = 3'd5,
    ST_PRE      = 3'd6
  } state_e;

  typedef struct packed {
    logic nras;
    logic ncas;
    logic rasel;
    logic ready;
    logic ref_ack;
  } pin_s;

  localparam pin_s PINS_IDLE = '{nras: 1'b1, ncas: 1'b1, rasel: 1'b0,
                                 ready: 1'b0, ref_ack: 1'b0};

  function automatic pin_s pins_for(input state_e st);
    pin_s p;
    p = PINS_IDLE;
    case (st)
      ST_ACC_RAS: p.nras = 1'b0;
      ST_ACC_CAS, ST_ACC_HOLD: begin
        p.nras  = 1'b0;
        p.ncas  = 1'b0;
        p.rasel = 1'b1;
        p.ready = 1'b1;
      end
      ST_REF_CAS: begin
        p.ncas    = 1'b0;
        p.ref_ack = 1'b1;
      end
      ST_REF_RAS: begin
        p.nras = 1'b0;
        p.ncas = 1'b0;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

  // Dwell counters are loaded with (cycles - 1) so zero means "last cycle".
  function automatic logic [CNT_W-1:0] cnt_init(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_cycle_sched_tmr.sv
// Loadable down-counter that times the dwell of each scheduler state.
module dram_tmr
  import dram_cycle_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dram_cycle_sched.sv
// Arbitrates the shared DRAM array between FSB accesses and CAS-before-RAS
// refresh, and drives registered RAS/CAS/RASEL/Ready/RefAck.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | array precharged, arbitrating every edge
// ACC_RAS  | row strobe low, row address on the mux (TRCD cycles)
// ACC_CAS  | column strobe low, Ready high (one cycle)
// ACC_HOLD | column strobe low, Ready high until BACT falls
// REF_CAS  | CAS before RAS, RefAck pulse (one cycle)
// REF_RAS  | RAS and CAS low for TRAS_REF cycles
// PRE      | both strobes high for TRP cycles
module dram_cycle_sched
  import dram_cycle_sched_pkg::*;
#(
  parameter int unsigned TRCD     = TRCD_DEF,
  parameter int unsigned TRAS_REF = TRAS_REF_DEF,
  parameter int unsigned TRP      = TRP_DEF
) (
  input  logic CLK_FSB,
  input  logic nRES,
  input  logic BACT,
  input  logic RAMCS,
  input  logic RefReq,
  input  logic RefUrgent,
  output logic RefAck,
  output logic nRAS,
  output logic nCAS,
  output logic RASEL,
  output logic Ready
);

  state_e           state_q;
  state_e           state_d;
  state_e           arb_st;
  pin_s             pins_q;
  pin_s             pins_d;
  logic             acc_req;
  logic             tmr_zero;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;

  assign acc_req = BACT && RAMCS;

  always_comb begin
    arb_st = ST_IDLE;
    if (RefReq && RefUrgent) begin
      arb_st = ST_REF_CAS;
    end else if (acc_req) begin
      arb_st = ST_ACC_RAS;
    end else if (RefReq) begin
      arb_st = ST_REF_CAS;
    end
  end

  // PRE hands straight to arbitration so back-to-back cycles pay only TRP,
  // not an extra IDLE clock on top of it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = arb_st;
      ST_ACC_RAS: begin
        if (!BACT) begin
          state_d = ST_PRE;
        end else if (tmr_zero) begin
          state_d = ST_ACC_CAS;
        end
      end
      ST_ACC_CAS: state_d = ST_ACC_HOLD;
      ST_ACC_HOLD: begin
        if (!BACT) begin
          state_d = ST_PRE;
        end
      end
      ST_REF_CAS: state_d = ST_REF_RAS;
      ST_REF_RAS: begin
        if (tmr_zero) begin
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (tmr_zero) begin
          state_d = arb_st;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_ACC_RAS: tmr_val = cnt_init(TRCD);
      ST_REF_RAS: tmr_val = cnt_init(TRAS_REF);
      ST_PRE:     tmr_val = cnt_init(TRP);
      default:    tmr_val = '0;
    endcase
  end

  assign pins_d = pins_for(state_d);

  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      state_q <= ST_IDLE;
      pins_q  <= PINS_IDLE;
    end else begin
      state_q <= state_d;
      pins_q  <= pins_d;
    end
  end

  dram_tmr u_tmr (
    .clk      (CLK_FSB),
    .rst_n    (nRES),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign nRAS   = pins_q.nras;
  assign nCAS   = pins_q.ncas;
  assign RASEL  = pins_q.rasel;
  assign Ready  = pins_q.ready;
  assign RefAck = pins_q.ref_ack;

endmodule

// File: tb/tb_dram_cycle_sched.sv
// Bench for dram_cycle_sched: waveform-queue reference model compared every
// cycle, directed timing scenarios with literal expectations, random traffic.
module tb_dram_cycle_sched;

  localparam int TRCD     = 2;
  localparam int TRAS_REF = 3;
  localparam int TRP      = 2;

  // {nRAS, nCAS, RASEL, Ready, RefAck}
  localparam logic [4:0] V_IDLE = 5'b11000;
  localparam logic [4:0] V_ROW  = 5'b01000;
  localparam logic [4:0] V_COL  = 5'b00110;
  localparam logic [4:0] V_RCAS = 5'b10001;
  localparam logic [4:0] V_RRAS = 5'b00000;
  localparam logic [4:0] V_PRE  = 5'b11000;

  logic CLK_FSB;
  logic nRES;
  logic BACT;
  logic RAMCS;
  logic RefReq;
  logic RefUrgent;
  logic RefAck;
  logic nRAS;
  logic nCAS;
  logic RASEL;
  logic Ready;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  dram_cycle_sched #(
    .TRCD     (TRCD),
    .TRAS_REF (TRAS_REF),
    .TRP      (TRP)
  ) dut (
    .CLK_FSB   (CLK_FSB),
    .nRES      (nRES),
    .BACT      (BACT),
    .RAMCS     (RAMCS),
    .RefReq    (RefReq),
    .RefUrgent (RefUrgent),
    .RefAck    (RefAck),
    .nRAS      (nRAS),
    .nCAS      (nCAS),
    .RASEL     (RASEL),
    .Ready     (Ready)
  );

  initial CLK_FSB = 1'b0;
  always #5 CLK_FSB = ~CLK_FSB;

  // Model: fixed-length segments (refresh, precharge) are queued as whole
  // waveforms; the access row/column phases depend on BACT and are counted.
  logic [4:0] exp_cur = V_IDLE;
  logic [4:0] seg_q[$];
  int         row_left = 0;
  bit         in_col = 0;
  int         col_n = 0;

  task automatic push_pre();
    for (int i = 0; i < TRP; i++) seg_q.push_back(V_PRE);
  endtask

  task automatic model_step();
    logic [4:0] nxt;
    bit acc;
    acc = BACT && RAMCS;
    if (row_left > 0) begin
      if (!BACT) begin
        row_left = 0;
        push_pre();
        nxt = seg_q.pop_front();
      end else begin
        row_left--;
        if (row_left > 0) begin
          nxt = V_ROW;
        end else begin
          in_col = 1;
          col_n  = 0;
          nxt    = V_COL;
        end
      end
    end else if (in_col) begin
      col_n++;
      if (col_n >= 2 && !BACT) begin
        in_col = 0;
        push_pre();
        nxt = seg_q.pop_front();
      end else begin
        nxt = V_COL;
      end
    end else if (seg_q.size() > 0) begin
      nxt = seg_q.pop_front();
    end else if (RefReq && (RefUrgent || !acc)) begin
      seg_q.push_back(V_RCAS);
      for (int i = 0; i < TRAS_REF; i++) seg_q.push_back(V_RRAS);
      push_pre();
      nxt = seg_q.pop_front();
    end else if (acc) begin
      row_left = TRCD;
      nxt = V_ROW;
    end else begin
      nxt = V_IDLE;
    end
    exp_cur = nxt;
  endtask

  always @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      seg_q.delete();
      row_left = 0;
      in_col   = 0;
      col_n    = 0;
      exp_cur  = V_IDLE;
    end else begin
      model_step();
    end
  end

  always @(negedge CLK_FSB) begin
    if (cmp_en) begin
      total++;
      if ({nRAS, nCAS, RASEL, Ready, RefAck} !== exp_cur) begin
        bad++;
        $display("FAIL model_cmp t=%0t: got {nRAS,nCAS,RASEL,Ready,RefAck}=%b want %b",
                 $time, {nRAS, nCAS, RASEL, Ready, RefAck}, exp_cur);
      end
    end
  end

  task automatic tick();
    @(posedge CLK_FSB);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {nRAS, nCAS, RASEL, Ready, RefAck};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %b want %b", name, $time, got, exp);
    end
  endtask

  task automatic clear_inputs();
    BACT = 0; RAMCS = 0; RefReq = 0; RefUrgent = 0;
  endtask

  task automatic idle_access(input string tag);
    BACT = 1; RAMCS = 1;
    tick(); chk({tag, "_c1_row"}, V_ROW);
    tick(); chk({tag, "_c2_row"}, V_ROW);
    tick(); chk({tag, "_c3_col"}, V_COL);
    tick(); tick(); tick();
    chk({tag, "_c6_hold"}, V_COL);
    BACT = 0; RAMCS = 0;
    tick(); chk({tag, "_c7_pre"}, V_PRE);
    tick(); chk({tag, "_c8_pre"}, V_PRE);
    tick(); chk({tag, "_c9_idle"}, V_IDLE);
  endtask

  task automatic refresh_tail(input string tag, input int first_cycle);
    for (int i = 0; i < TRAS_REF; i++) begin
      tick(); chk($sformatf("%s_c%0d_refras", tag, first_cycle + i), V_RRAS);
    end
    for (int i = 0; i < TRP; i++) begin
      tick(); chk($sformatf("%s_c%0d_pre", tag, first_cycle + TRAS_REF + i), V_PRE);
    end
  endtask

  int bus_left;

  initial begin
    nRES = 0;
    clear_inputs();
    repeat (3) @(negedge CLK_FSB);
    chk("reset_state", V_IDLE);
    #2 nRES = 1;
    cmp_en = 1;
    tick();

    idle_access("idle_acc");

    // Non-urgent refresh with the bus idle.
    RefReq = 1;
    tick(); chk("ref_c1_ack", V_RCAS);
    RefReq = 0;
    refresh_tail("ref", 2);
    tick(); chk("ref_c7_idle", V_IDLE);

    // Non-urgent refresh tied with an access: access first.
    RefReq = 1; BACT = 1; RAMCS = 1;
    tick(); chk("cont_c1_row", V_ROW);
    tick(); tick(); chk("cont_c3_col", V_COL);
    tick(); BACT = 0; RAMCS = 0;
    tick(); chk("cont_c5_pre", V_PRE);
    tick(); chk("cont_c6_pre", V_PRE);
    tick(); chk("cont_c7_ack", V_RCAS);
    RefReq = 0;
    refresh_tail("cont", 8);
    tick(); chk("cont_c13_idle", V_IDLE);

    // Urgent refresh tied with an access: refresh first, Ready 9 cycles on.
    RefReq = 1; RefUrgent = 1; BACT = 1; RAMCS = 1;
    tick(); chk("urg_c1_ack", V_RCAS);
    RefReq = 0; RefUrgent = 0;
    refresh_tail("urg", 2);
    tick(); chk("urg_c7_row", V_ROW);
    tick(); chk("urg_c8_row", V_ROW);
    tick(); chk("urg_c9_ready", V_COL);
    tick(); BACT = 0; RAMCS = 0;
    tick(); chk("urg_c11_pre", V_PRE);
    tick(); tick(); chk("urg_c13_idle", V_IDLE);

    // ROM/IO bus cycle overlapping a refresh.
    BACT = 1; RAMCS = 0; RefReq = 1;
    tick(); chk("rom_c1_ack", V_RCAS);
    RefReq = 0;
    refresh_tail("rom", 2);
    tick(); chk("rom_c7_idle", V_IDLE);
    BACT = 0;
    tick();

    // Reset pulse in the middle of REF_RAS acts without waiting for an edge.
    RefReq = 1;
    tick(); chk("rst_c1_ack", V_RCAS);
    RefReq = 0;
    tick(); tick(); chk("rst_c3_refras", V_RRAS);
    #2 nRES = 0;
    #1 chk("rst_async", V_IDLE);
    @(negedge CLK_FSB);
    @(negedge CLK_FSB);
    #2 nRES = 1;
    tick();
    idle_access("post_rst");

    // Random traffic against the model.
    bus_left = 0;
    repeat (3000) begin
      tick();
      if (bus_left == 0) begin
        if (BACT) begin
          BACT = 0; RAMCS = 0;
          bus_left = $urandom_range(0, 4);
        end else begin
          BACT = 1;
          RAMCS = ($urandom_range(0, 3) != 0);
          bus_left = $urandom_range(1, 12);
        end
      end else begin
        bus_left--;
      end
      if (RefAck) begin
        RefReq = 0; RefUrgent = 0;
      end else if (!RefReq && $urandom_range(0, 19) == 0) begin
        RefReq = 1;
        RefUrgent = ($urandom_range(0, 2) == 0);
      end else if (RefReq && $urandom_range(0, 49) == 0) begin
        RefReq = 0; RefUrgent = 0;
      end else if (RefReq && !RefUrgent && $urandom_range(0, 29) == 0) begin
        RefUrgent = 1;
      end
    end

    clear_inputs();
    repeat (20) tick();
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
